// File: rtl/orb_seq_pkg.sv
// Shared types and constants for the ORB frame sequencer: FSM states, stage
// codes used in err_stage, and watchdog sizing constants.
package orb_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT_GO,
        ST_EXT_WAIT,
        ST_FAST_GO,
        ST_FAST_WAIT,
        ST_DESC_GO,
        ST_DESC_WAIT,
        ST_DONE
    } seq_state_t;

    typedef enum logic [1:0] {
        STG_NONE = 2'd0,
        STG_EXT  = 2'd1,
        STG_FAST = 2'd2,
        STG_DESC = 2'd3
    } stage_t;

    // Border fill of a 571x438 extended image is the longest stage.
    localparam int BORDER_FILL_CYC = 250098;
    localparam int TMO_CYC_DEF     = 300000;

    function automatic stage_t wait_stage(input seq_state_t s);
        case (s)
            ST_EXT_WAIT:  return STG_EXT;
            ST_FAST_WAIT: return STG_FAST;
            ST_DESC_WAIT: return STG_DESC;
            default:      return STG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/orb_seq_watchdog.sv
// Per-stage watchdog: cleared outside wait states, counts while enabled,
// flags expiry on the cycle the count reaches TMO_CYC-1. Never wraps.
module orb_seq_watchdog
    import orb_seq_pkg::*;
#(
    parameter int TMO_W   = 20,
    parameter int TMO_CYC = TMO_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [TMO_W-1:0] EXP_VAL = TMO_W'(TMO_CYC - 1);
    localparam logic [TMO_W-1:0] CNT_MAX = '1;

    logic [TMO_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = en && (cnt_q == EXP_VAL);

endmodule

// File: rtl/orb_frame_sequencer.sv
// Per-frame ORB front-end sequencer: border -> FAST -> descriptor for each
// pyramid level, with one queued frame request and a per-stage watchdog.
module orb_frame_sequencer
    import orb_seq_pkg::*;
#(
    parameter int NUM_LEVELS = 4,
    parameter int TMO_W      = 20,
    parameter int TMO_CYC    = TMO_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_req,
    input  logic       abort,
    output logic       ext_start,
    input  logic       ext_done,
    output logic       fast_start,
    input  logic       fast_done,
    output logic       desc_start,
    input  logic       desc_done,
    output logic [1:0] level,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun,
    output logic       err_tmo,
    output logic [1:0] err_stage,
    input  logic       err_clr
);

    localparam logic [1:0] LAST_LVL = 2'(NUM_LEVELS - 1);

    seq_state_t state_q, state_d;
    logic [1:0] level_q, level_d;
    logic       pending_q, pending_d;
    logic       overrun_q, overrun_d;
    logic       err_tmo_q, err_tmo_d;
    stage_t     err_stage_q, err_stage_d;

    // Index 0 = ext, 1 = fast, 2 = desc. Edges are registered so a done
    // level held for several cycles advances the FSM only once.
    logic [2:0] done_in, done_d1_q, done_edge_q, done_edge_d;
    logic       cur_edge, wd_en, wd_expire;
    stage_t     cur_stage;

    assign done_in     = {desc_done, fast_done, ext_done};
    assign done_edge_d = done_in & ~done_d1_q;

    assign wd_en = (state_q == ST_EXT_WAIT) || (state_q == ST_FAST_WAIT) ||
                   (state_q == ST_DESC_WAIT);

    orb_seq_watchdog #(
        .TMO_W   (TMO_W),
        .TMO_CYC (TMO_CYC)
    ) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!wd_en),
        .en     (wd_en),
        .expire (wd_expire)
    );

    always_comb begin
        cur_stage = wait_stage(state_q);
        case (state_q)
            ST_EXT_WAIT:  cur_edge = done_edge_q[0];
            ST_FAST_WAIT: cur_edge = done_edge_q[1];
            ST_DESC_WAIT: cur_edge = done_edge_q[2];
            default:      cur_edge = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        pending_d   = pending_q;
        overrun_d   = overrun_q;
        err_tmo_d   = err_tmo_q;
        err_stage_d = err_stage_q;

        // Clear first so a same-cycle error below still lands.
        if (err_clr) begin
            overrun_d   = 1'b0;
            err_tmo_d   = 1'b0;
            err_stage_d = STG_NONE;
        end

        if (abort) begin
            state_d   = ST_IDLE;
            level_d   = '0;
            pending_d = 1'b0;
        end else begin
            if (frame_req && (state_q != ST_IDLE)) begin
                if (pending_q) overrun_d = 1'b1;
                else           pending_d = 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (frame_req || pending_q) begin
                        state_d   = ST_EXT_GO;
                        level_d   = '0;
                        pending_d = 1'b0;
                    end
                end
                ST_EXT_GO:  state_d = ST_EXT_WAIT;
                ST_FAST_GO: state_d = ST_FAST_WAIT;
                ST_DESC_GO: state_d = ST_DESC_WAIT;
                ST_EXT_WAIT, ST_FAST_WAIT, ST_DESC_WAIT: begin
                    if (cur_edge) begin
                        case (state_q)
                            ST_EXT_WAIT:  state_d = ST_FAST_GO;
                            ST_FAST_WAIT: state_d = ST_DESC_GO;
                            default: begin
                                if (level_q < LAST_LVL) begin
                                    level_d = level_q + 2'd1;
                                    state_d = ST_EXT_GO;
                                end else begin
                                    state_d = ST_DONE;
                                end
                            end
                        endcase
                    end else if (wd_expire) begin
                        err_tmo_d   = 1'b1;
                        err_stage_d = cur_stage;
                        pending_d   = 1'b0;
                        level_d     = '0;
                        state_d     = ST_IDLE;
                    end
                end
                ST_DONE: begin
                    level_d = '0;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            level_q     <= '0;
            pending_q   <= 1'b0;
            overrun_q   <= 1'b0;
            err_tmo_q   <= 1'b0;
            err_stage_q <= STG_NONE;
            done_d1_q   <= '0;
            done_edge_q <= '0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            err_tmo_q   <= err_tmo_d;
            err_stage_q <= err_stage_d;
            done_d1_q   <= done_in;
            done_edge_q <= done_edge_d;
        end
    end

    assign ext_start  = (state_q == ST_EXT_GO);
    assign fast_start = (state_q == ST_FAST_GO);
    assign desc_start = (state_q == ST_DESC_GO);
    assign frame_done = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign level      = level_q;
    assign overrun    = overrun_q;
    assign err_tmo    = err_tmo_q;
    assign err_stage  = err_stage_q;

endmodule

// File: tb/tb_orb_frame_sequencer.sv
// Randomized bench for orb_frame_sequencer: expected start/done cycles are
// derived from the done-to-start latency and watchdog rules with plain arithmetic.
module tb_orb_frame_sequencer;

    localparam int NL  = 2;
    localparam int TMO = 100;
    localparam int LAT = 2;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       frame_req = 1'b0, abort = 1'b0, err_clr = 1'b0;
    logic       ext_done = 1'b0, fast_done = 1'b0, desc_done = 1'b0;
    logic       ext_start, fast_start, desc_start, busy, frame_done;
    logic       overrun, err_tmo;
    logic [1:0] level, err_stage;

    orb_frame_sequencer #(.NUM_LEVELS(NL), .TMO_W(20), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .frame_req(frame_req), .abort(abort),
        .ext_start(ext_start), .ext_done(ext_done),
        .fast_start(fast_start), .fast_done(fast_done),
        .desc_start(desc_start), .desc_done(desc_done),
        .level(level), .busy(busy), .frame_done(frame_done),
        .overrun(overrun), .err_tmo(err_tmo), .err_stage(err_stage),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_chk = 0, n_fail = 0;
    int cnt_st [3] = '{0, 0, 0};
    int cnt_fd = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (ext_start)  cnt_st[0] <= cnt_st[0] + 1;
            if (fast_start) cnt_st[1] <= cnt_st[1] + 1;
            if (desc_start) cnt_st[2] <= cnt_st[2] + 1;
            if (frame_done) cnt_fd    <= cnt_fd + 1;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic nxt;
        @(negedge clk);
    endtask

    function automatic logic sig(input int k);
        case (k)
            0:       return ext_start;
            1:       return fast_start;
            2:       return desc_start;
            default: return frame_done;
        endcase
    endfunction

    task automatic set_done(input int k, input logic v);
        case (k)
            0:       ext_done  = v;
            1:       fast_done = v;
            default: desc_done = v;
        endcase
    endtask

    // Waits (bounded) for output k; a missing or late pulse is a failed check.
    task automatic wait_for(input int k, input int exp_cyc, input string tag, output int got);
        int lim;
        got = -1;
        lim = exp_cyc - cyc + 6;
        if (lim > 1000) lim = 1000;
        for (int i = 0; i < lim; i++) begin
            if (sig(k)) begin
                got = cyc;
                break;
            end
            nxt;
        end
        chk(tag, got, exp_cyc);
    endtask

    // Sees the start, answers with done after a random delay; optionally
    // injects frame_req pulses while the stage is waiting.
    task automatic run_stage(input int k, input int lvl, input int exp_cyc,
                             input int nreq, output int t_done);
        int g, d, w;
        wait_for(k, exp_cyc, $sformatf("start%0d_l%0d_cyc", k, lvl), g);
        chk($sformatf("level_at_start%0d", k), int'(level), lvl);
        d = (nreq > 0) ? 12 : $urandom_range(1, 20);
        w = (k == 0) ? 2 : $urandom_range(1, 2);
        for (int i = 0; i < d; i++) begin
            nxt;
            frame_req = (i < 2 * nreq) && (i % 2 == 0);
        end
        frame_req = 1'b0;
        set_done(k, 1'b1);
        t_done = cyc;
        repeat (w) nxt;
        set_done(k, 1'b0);
    endtask

    // Runs a frame whose first ext_start is expected at first_exp. Stops at
    // the start of stage (stop_lvl, stop_k) if given, returning its cycle;
    // otherwise returns the frame_done cycle.
    task automatic do_frame(input int first_exp, input int stop_lvl, input int stop_k,
                            input int nreq, input logic req_at_done, output int res);
        int exp_c, t, g;
        exp_c = first_exp;
        for (int lvl = 0; lvl < NL; lvl++) begin
            for (int k = 0; k < 3; k++) begin
                if (lvl == stop_lvl && k == stop_k) begin
                    wait_for(k, exp_c, $sformatf("stop_start%0d_l%0d", k, lvl), g);
                    res = g;
                    return;
                end
                run_stage(k, lvl, exp_c, (lvl == 0 && k == 0) ? nreq : 0, t);
                exp_c = t + LAT;
            end
        end
        wait_for(3, exp_c, "frame_done_cyc", g);
        frame_req = req_at_done;
        nxt;
        frame_req = 1'b0;
        chk("busy_after_done", int'(busy), 0);
        res = g;
    endtask

    task automatic req_pulse(output int c);
        c = cyc;
        frame_req = 1'b1;
        nxt;
        frame_req = 1'b0;
    endtask

    task automatic clr_pulse;
        err_clr = 1'b1;
        nxt;
        err_clr = 1'b0;
    endtask

    initial begin
        int c, r, g, x, fd0, st0;
        repeat (3) nxt;
        chk("reset_outs", int'({ext_start, fast_start, desc_start, level, busy,
                                frame_done, overrun, err_tmo, err_stage}), 0);
        rst_n = 1'b1;
        repeat (2) nxt;

        // Plain frames with random stage latencies.
        for (int f = 0; f < 4; f++) begin
            st0 = cnt_st[1];
            fd0 = cnt_fd;
            req_pulse(c);
            do_frame(c + 1, -1, -1, 0, 1'b0, r);
            chk("fast_starts_per_frame", cnt_st[1] - st0, NL);
            chk("frame_done_per_frame", cnt_fd - fd0, 1);
            repeat ($urandom_range(1, 5)) nxt;
        end

        // One request queues, further ones overrun and are dropped.
        st0 = cnt_st[0];
        fd0 = cnt_fd;
        req_pulse(c);
        do_frame(c + 1, -1, -1, 3, 1'b0, r);
        chk("overrun_set", int'(overrun), 1);
        do_frame(r + 2, -1, -1, 0, 1'b0, r);
        repeat (20) nxt;
        chk("no_third_frame_busy", int'(busy), 0);
        chk("ext_starts_two_frames", cnt_st[0] - st0, 2 * NL);
        chk("frame_done_two_frames", cnt_fd - fd0, 2);
        clr_pulse;
        chk("overrun_cleared", int'(overrun), 0);

        // frame_req landing on the frame_done cycle chains the next frame.
        req_pulse(c);
        do_frame(c + 1, -1, -1, 0, 1'b1, r);
        do_frame(r + 2, -1, -1, 0, 1'b0, r);
        chk("no_overrun_single_pending", int'(overrun), 0);

        // fast_done withheld: watchdog fires after TMO wait cycles.
        req_pulse(c);
        do_frame(c + 1, 0, 1, 0, 1'b0, g);
        fd0 = cnt_fd;
        repeat (TMO) nxt;
        chk("tmo_not_early", int'(err_tmo), 0);
        nxt;
        chk("tmo_flag", int'(err_tmo), 1);
        chk("tmo_stage_fast", int'(err_stage), 2);
        chk("tmo_idle", int'(busy), 0);
        repeat (5) nxt;
        chk("tmo_no_frame_done", cnt_fd - fd0, 0);
        clr_pulse;
        chk("tmo_clr_flag", int'(err_tmo), 0);
        chk("tmo_clr_stage", int'(err_stage), 0);

        // Done edge on the expiry cycle wins; one cycle later is a timeout.
        req_pulse(c);
        do_frame(c + 1, 0, 1, 0, 1'b0, g);
        repeat (TMO - 1) nxt;
        fast_done = 1'b1;
        nxt;
        fast_done = 1'b0;
        wait_for(2, g + TMO + 1, "desc_start_on_expiry", x);
        chk("no_err_on_expiry_edge", int'(err_tmo), 0);
        repeat (TMO) nxt;
        desc_done = 1'b1;
        nxt;
        desc_done = 1'b0;
        chk("late_done_tmo", int'(err_tmo), 1);
        chk("late_done_stage", int'(err_stage), 3);
        chk("late_done_idle", int'(busy), 0);

        // Abort in level-1 DESC_WAIT; sticky error must survive it.
        req_pulse(c);
        fd0 = cnt_fd;
        do_frame(c + 1, 1, 2, 0, 1'b0, g);
        repeat ($urandom_range(1, 30)) nxt;
        abort = 1'b1;
        nxt;
        abort = 1'b0;
        chk("abort_idle", int'(busy), 0);
        chk("abort_level", int'(level), 0);
        chk("abort_keeps_err", int'(err_tmo), 1);
        desc_done = 1'b1;
        nxt;
        desc_done = 1'b0;
        repeat (10) nxt;
        chk("abort_no_frame_done", cnt_fd - fd0, 0);
        chk("abort_stays_idle", int'(busy), 0);
        clr_pulse;
        req_pulse(c);
        do_frame(c + 1, -1, -1, 0, 1'b0, r);
        chk("after_abort_frame_done", cnt_fd - fd0, 1);

        // Async reset mid FAST_WAIT with pending and overrun set.
        req_pulse(c);
        do_frame(c + 1, 1, 1, 0, 1'b0, g);
        nxt;
        frame_req = 1'b1; nxt; frame_req = 1'b0; nxt;
        frame_req = 1'b1; nxt; frame_req = 1'b0;
        chk("pre_reset_overrun", int'(overrun), 1);
        chk("pre_reset_level", int'(level), 1);
        repeat (3) nxt;
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_outs", int'({ext_start, fast_start, desc_start, level, busy,
                                      frame_done, overrun, err_tmo, err_stage}), 0);
        nxt;
        rst_n = 1'b1;
        repeat (10) nxt;
        chk("reset_drops_pending", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not complete, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
